// File: rtl/vram_pkg.sv
// Shared types and default geometry for the screen RAM scan arbiter.
package vram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fsm_state_t;

    localparam int COLS_DEF     = 32;
    localparam int ROWS_DEF     = 32;
    localparam int TILE_W_DEF   = 20;
    localparam int TILE_H_DEF   = 15;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_TOTAL_DEF  = 525;

    localparam logic [15:0] WIN_BASE = 16'h0200;

endpackage

// File: rtl/vram_scan_arbiter_if.sv
// CPU MMIO bus and single-port screen RAM bus seen by the scan arbiter.
interface vram_scan_arbiter_if;

    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;

    logic [9:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;

    // slave: the arbiter; master: CPU plus RAM side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output cpu_ack, cpu_rdata, ram_addr, ram_wdata, ram_we
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  cpu_ack, cpu_rdata, ram_addr, ram_wdata, ram_we
    );

endinterface

// File: rtl/vram_line_buffer.sv
// One tile row of bytes: single write port filled by the row fetch, registered read port for scanout.
module vram_line_buffer
    import vram_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int W    = 8,
    parameter int AW   = $clog2(COLS)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [COLS];

    // storage is deliberately unreset; the top masks it until a row has landed
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rdata <= '0;
        else          rdata <= mem[raddr];
    end

endmodule

// File: rtl/vram_scan_arbiter.sv
// Screen RAM owner: hblank row prefetch into a line buffer, CPU MMIO access while idle.
// Optional feature: define VRAM_CPU_READ_EN to let CPU reads inside the window reach the RAM.
module vram_scan_arbiter
    import vram_pkg::*;
#(
    parameter int COLS     = COLS_DEF,
    parameter int ROWS     = ROWS_DEF,
    parameter int TILE_W   = TILE_W_DEF,
    parameter int TILE_H   = TILE_H_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF
) (
    input  logic                clock,
    input  logic                reset_n,
    vram_scan_arbiter_if.slave  bus,
    input  logic [9:0]          x_addr,
    input  logic [9:0]          y_addr,
    output logic [7:0]          pixel_data,
    output logic                pixel_valid,
    output logic                fetch_late
);

    localparam int CW        = $clog2(COLS);
    localparam int RW        = $clog2(ROWS);
    localparam int PW        = $clog2(TILE_W);
    localparam int WIN_SIZE  = COLS * ROWS;
    localparam int VIS_LINES = ROWS * TILE_H;

    fsm_state_t    state, state_nxt;
    logic [CW-1:0] col, col_nxt;
    logic [RW-1:0] row, row_nxt;
    logic [9:0]    x_prev;
    logic          x_chg;
    logic          trig;
    logic [RW-1:0] trig_row;
    logic          live;
    logic          accept, in_win, cpu_ram;
    logic [9:0]    win_off;
    logic          cpu_ack_q;
    logic          cap_vld;
    logic [CW-1:0] cap_idx;
    logic          buf_valid;
    logic [CW:0]   tcol, tcol_nxt;
    logic [PW-1:0] tpix, tpix_nxt;
    logic [7:0]    lb_rdata;

    assign x_chg = (x_addr != x_prev);

    // Row-start lines are fixed constants, so the match is a bank of equality compares.
    always_comb begin
        trig     = 1'b0;
        trig_row = '0;
        if (x_chg && x_addr == 10'(H_ACTIVE)) begin
            if (y_addr == 10'(V_TOTAL - 1)) trig = 1'b1;
            for (int r = 1; r < ROWS; r++) begin
                if (y_addr == 10'(r * TILE_H - 1)) begin
                    trig     = 1'b1;
                    trig_row = RW'(r);
                end
            end
        end
    end

    assign in_win  = (bus.cpu_addr >= WIN_BASE) && (bus.cpu_addr < WIN_BASE + 16'(WIN_SIZE));
    assign win_off = 10'(bus.cpu_addr - WIN_BASE);
    assign accept  = live && (state == IDLE) && bus.cpu_req && !cpu_ack_q;

`ifdef VRAM_CPU_READ_EN
    logic rd_pend;
    assign cpu_ram       = in_win;
    assign bus.cpu_rdata = (cpu_ack_q && rd_pend) ? bus.ram_rdata : 8'h00;
`else
    assign cpu_ram       = in_win && bus.cpu_we;
    assign bus.cpu_rdata = 8'h00;
`endif

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        unique case (state)
            IDLE: begin
                // a CPU access accepted this cycle finishes now; the fetch begins next clock
                if (trig) begin
                    state_nxt = FETCH;
                    col_nxt   = '0;
                    row_nxt   = trig_row;
                end
            end
            FETCH: begin
                col_nxt = col + CW'(1);
                if (col == CW'(COLS - 1)) state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ram_addr  = '0;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = '0;
        if (state == FETCH) begin
            bus.ram_addr = 10'(int'(row) * COLS + int'(col));
        end else if (accept && cpu_ram) begin
            bus.ram_addr  = win_off;
            bus.ram_we    = bus.cpu_we;
            bus.ram_wdata = bus.cpu_we ? bus.cpu_wdata : 8'h00;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            x_prev    <= '0;
            live      <= 1'b0;
            cpu_ack_q <= 1'b0;
            cap_vld   <= 1'b0;
            cap_idx   <= '0;
            buf_valid <= 1'b0;
            fetch_late  <= 1'b0;
            pixel_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            col       <= col_nxt;
            row       <= row_nxt;
            x_prev    <= x_addr;
            live      <= 1'b1;
            cpu_ack_q <= accept;
            // RAM answers one clock after the address, so capture trails issue by one
            cap_vld   <= (state == FETCH);
            cap_idx   <= col;
            if (state == DRAIN) buf_valid <= 1'b1;
            if (x_chg && x_addr == 10'd0 && y_addr < 10'(VIS_LINES) && state != IDLE)
                fetch_late <= 1'b1;
            pixel_valid <= (x_addr < 10'(H_ACTIVE)) && (y_addr < 10'(VIS_LINES));
        end
    end

`ifdef VRAM_CPU_READ_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rd_pend <= 1'b0;
        else          rd_pend <= accept && in_win && !bus.cpu_we;
    end
`endif

    assign bus.cpu_ack = cpu_ack_q;

    always_comb begin
        tcol_nxt = tcol;
        tpix_nxt = tpix;
        if (x_chg) begin
            if (x_addr == 10'd0) begin
                tcol_nxt = '0;
                tpix_nxt = '0;
            end else if (tpix == PW'(TILE_W - 1)) begin
                tcol_nxt = tcol + (CW+1)'(1);
                tpix_nxt = '0;
            end else begin
                tpix_nxt = tpix + PW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tcol <= '0;
            tpix <= '0;
        end else begin
            tcol <= tcol_nxt;
            tpix <= tpix_nxt;
        end
    end

    // read with the next column so the byte lands one clock after the x change
    vram_line_buffer #(.COLS(COLS), .W(8)) u_lbuf (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (cap_vld),
        .waddr   (cap_idx),
        .wdata   (bus.ram_rdata),
        .raddr   (tcol_nxt[CW-1:0]),
        .rdata   (lb_rdata)
    );

    assign pixel_data = buf_valid ? lb_rdata : 8'h00;

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Directed bench for vram_scan_arbiter with a behavioural 1-clock-latency screen RAM.
module tb_vram_scan_arbiter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [9:0] x_addr, y_addr;
    logic [7:0] pixel_data;
    logic       pixel_valid, fetch_late;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] ram [1024];

    vram_scan_arbiter_if bus();

    vram_scan_arbiter dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .x_addr      (x_addr),
        .y_addr      (y_addr),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .fetch_late  (fetch_late)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= ram[bus.ram_addr];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        x_addr = 10'd700; y_addr = 10'd500;
        tick(); tick();
        checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b want=0", bus.cpu_ack); end
        checks++; if (bus.ram_we !== 1'b0 || bus.ram_addr !== 10'd0) begin errors++; $display("FAIL reset_ram we=%b addr=%0d want 0/0", bus.ram_we, bus.ram_addr); end
        checks++; if (pixel_data !== 8'h00 || pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_pixel data=%h valid=%b want 0/0", pixel_data, pixel_valid); end
        checks++; if (fetch_late !== 1'b0 || bus.cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_late late=%b rdata=%h want 0/0", fetch_late, bus.cpu_rdata); end
        reset_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_cpu_write();
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h0205; bus.cpu_wdata = 8'hAA;
        #1;
        checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 10'd5 || bus.ram_wdata !== 8'hAA) begin
            errors++; $display("FAIL cpu_write_ram we=%b addr=%0d data=%h want 1/5/aa", bus.ram_we, bus.ram_addr, bus.ram_wdata); end
        checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL cpu_write_early_ack got=%b want=0", bus.cpu_ack); end
        tick();
        checks++; if (bus.cpu_ack !== 1'b1) begin errors++; $display("FAIL cpu_write_ack got=%b want=1", bus.cpu_ack); end
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL cpu_write_once ram_we=%b want=0", bus.ram_we); end
        bus.cpu_req = 0;
        tick();
        checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL cpu_write_ack_pulse got=%b want=0", bus.cpu_ack); end
    endtask

    task automatic test_out_of_window();
        logic [15:0] addrs [2];
        addrs[0] = 16'h0600; addrs[1] = 16'h01FF;
        for (int i = 0; i < 2; i++) begin
            bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = addrs[i]; bus.cpu_wdata = 8'h5A;
            #1;
            checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL oow_we addr=%h ram_we=%b want=0", addrs[i], bus.ram_we); end
            tick();
            checks++; if (bus.cpu_ack !== 1'b1 || bus.ram_we !== 1'b0) begin
                errors++; $display("FAIL oow_ack addr=%h ack=%b we=%b want 1/0", addrs[i], bus.cpu_ack, bus.ram_we); end
            bus.cpu_req = 0;
            tick();
        end
    endtask

    task automatic test_cpu_read();
        logic [7:0] exp;
`ifdef VRAM_CPU_READ_EN
        exp = 8'hAA;
`else
        exp = 8'h00;
`endif
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0205;
        #1;
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL read_we ram_we=%b want=0", bus.ram_we); end
        tick();
        checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== exp) begin
            errors++; $display("FAIL read_data ack=%b rdata=%h want 1/%h", bus.cpu_ack, bus.cpu_rdata, exp); end
        bus.cpu_req = 0;
        tick();
    endtask

    // Drive an x 639->640 step on line y and check the address stream that follows.
    task automatic run_line_end(input logic [9:0] y, input logic [9:0] base, input bit expect_fetch);
        y_addr = y; x_addr = 10'd639;
        tick();
        x_addr = 10'd640;
        tick();
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (expect_fetch) begin
                if (bus.ram_addr !== base + 10'(i)) begin
                    errors++; $display("FAIL fetch_addr y=%0d i=%0d got=%0d want=%0d", y, i, bus.ram_addr, base + 10'(i)); end
            end else if (bus.ram_addr !== 10'd0) begin
                errors++; $display("FAIL no_fetch y=%0d i=%0d got=%0d want=0", y, i, bus.ram_addr);
            end
            tick();
        end
        checks++; if (bus.ram_addr !== 10'd0) begin errors++; $display("FAIL drain_addr y=%0d got=%0d want=0", y, bus.ram_addr); end
        tick();
    endtask

    task automatic test_row_bounds();
        run_line_end(10'd524, 10'd0,   1'b1);
        run_line_end(10'd464, 10'd992, 1'b1);
        run_line_end(10'd479, 10'd0,   1'b0);
    endtask

    task automatic test_fetch_scan();
        logic [7:0] exp;
        run_line_end(10'd14, 10'd32, 1'b1);
        y_addr = 10'd15;
        for (int x = 0; x < 640; x++) begin
            x_addr = 10'(x);
            tick();
            if (x % 20 == 0 || x == 639) begin
                exp = ram[32 + x / 20];
                checks++; if (pixel_data !== exp || pixel_valid !== 1'b1) begin
                    errors++; $display("FAIL scan x=%0d data=%h valid=%b want %h/1", x, pixel_data, pixel_valid, exp); end
            end
        end
        checks++; if (fetch_late !== 1'b0) begin errors++; $display("FAIL late_idle got=%b want=0", fetch_late); end
    endtask

    task automatic test_cpu_during_fetch();
        int we_at, ack_at;
        logic [9:0] we_addr;
        we_at = -1; ack_at = -1; we_addr = '0;
        y_addr = 10'd29; x_addr = 10'd639;
        tick();
        x_addr = 10'd640;
        tick(); tick(); tick(); tick();
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h0210; bus.cpu_wdata = 8'h55;
        #1;
        checks++; if (bus.ram_addr !== 10'd67 || bus.ram_we !== 1'b0) begin
            errors++; $display("FAIL contend_fetch addr=%0d we=%b want 67/0", bus.ram_addr, bus.ram_we); end
        for (int n = 0; n < 40; n++) begin
            if (n > 0) #1;
            if (bus.ram_we === 1'b1 && we_at < 0) begin we_at = n; we_addr = bus.ram_addr; end
            if (bus.cpu_ack === 1'b1) begin ack_at = n; break; end
            tick();
        end
        bus.cpu_req = 0;
        checks++; if (we_at != 30 || we_addr !== 10'd16) begin errors++; $display("FAIL contend_we at=%0d addr=%0d want 30/16", we_at, we_addr); end
        checks++; if (ack_at != 31) begin errors++; $display("FAIL contend_ack at=%0d want=31", ack_at); end
        tick(); tick();
    endtask

    task automatic test_fetch_late();
        y_addr = 10'd44; x_addr = 10'd639;
        tick();
        x_addr = 10'd640;
        tick(); tick(); tick(); tick();
        y_addr = 10'd45; x_addr = 10'd0;
        tick();
        checks++; if (fetch_late !== 1'b1) begin errors++; $display("FAIL late_set got=%b want=1", fetch_late); end
        repeat (40) tick();
        checks++; if (fetch_late !== 1'b1) begin errors++; $display("FAIL late_sticky got=%b want=1", fetch_late); end
    endtask

    task automatic test_reset_mid_fetch();
        y_addr = 10'd59; x_addr = 10'd639;
        tick();
        x_addr = 10'd640;
        tick();
        repeat (10) tick();
        checks++; if (bus.ram_addr !== 10'd138) begin errors++; $display("FAIL mid_col10 got=%0d want=138", bus.ram_addr); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.ram_addr !== 10'd0 || fetch_late !== 1'b0 || pixel_data !== 8'h00 || pixel_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset addr=%0d late=%b data=%h valid=%b want all 0", bus.ram_addr, fetch_late, pixel_data, pixel_valid); end
        x_addr = 10'd600;
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick();
        run_line_end(10'd59, 10'd128, 1'b1);
        y_addr = 10'd60;
        for (int x = 0; x <= 620; x++) begin
            x_addr = 10'(x);
            tick();
        end
        checks++; if (pixel_data !== ram[159]) begin errors++; $display("FAIL refetch_last got=%h want=%h", pixel_data, ram[159]); end
        x_addr = 10'd0;
        tick();
        checks++; if (pixel_data !== ram[128]) begin errors++; $display("FAIL refetch_first got=%h want=%h", pixel_data, ram[128]); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'(i * 7 + 3);
        bus.ram_rdata = 8'h00;
        test_reset();
        test_cpu_write();
        test_out_of_window();
        test_cpu_read();
        test_row_bounds();
        test_fetch_scan();
        test_cpu_during_fetch();
        test_fetch_late();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
